// File: rtl/mem_access_unit.sv
// Byte-serial sequencer between the CPU execute stage and the 4096x8 data memory.
// Word and byte loads/stores go out as one or two byte accesses; all outputs are registered.
module mem_access_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [11:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [15:0] cpu_rdata,
  output logic [11:0] mem_address,
  output logic [7:0]  mem_datain,
  output logic        mem_write_enable,
  input  logic [7:0]  mem_dataout
);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;

  localparam logic [2:0] LAT = 3'(MEM_RD_LAT);

  state_t      state, state_nxt;
  logic        op_we, op_we_nxt;
  logic        op_byte, op_byte_nxt;
  logic [11:0] op_addr, op_addr_nxt;
  logic [15:0] op_wdata, op_wdata_nxt;
  logic [7:0]  lo_q, lo_nxt, hi_q, hi_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        busy_nxt, done_nxt, we_nxt;
  logic [15:0] rdata_nxt;
  logic [11:0] addr_nxt;
  logic [7:0]  din_nxt;

  // Each state's effect lands on the edge that leaves it, so the memory
  // strobe and the done pulse trail the state register by one cycle.
  always_comb begin
    state_nxt    = state;
    op_we_nxt    = op_we;
    op_byte_nxt  = op_byte;
    op_addr_nxt  = op_addr;
    op_wdata_nxt = op_wdata;
    lo_nxt       = lo_q;
    hi_nxt       = hi_q;
    cnt_nxt      = cnt;
    busy_nxt     = cpu_busy;
    done_nxt     = 1'b0;
    we_nxt       = mem_write_enable;
    rdata_nxt    = cpu_rdata;
    addr_nxt     = mem_address;
    din_nxt      = mem_datain;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        we_nxt   = 1'b0;
        // busy is still high in the done cycle; a request then is dropped
        if (cpu_req && !cpu_busy) begin
          op_we_nxt    = cpu_we;
          op_byte_nxt  = cpu_byte;
          op_addr_nxt  = cpu_addr;
          op_wdata_nxt = cpu_wdata;
          addr_nxt     = cpu_addr;
          busy_nxt     = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = cpu_we ? WR_LO : RD_LO;
        end
      end
      WR_LO: begin
        we_nxt    = 1'b1;
        din_nxt   = op_wdata[7:0];
        state_nxt = op_byte ? DONE : WR_HI;
      end
      WR_HI: begin
        we_nxt    = 1'b1;
        addr_nxt  = op_addr + 12'd1;
        din_nxt   = op_wdata[15:8];
        state_nxt = DONE;
      end
      RD_LO: begin
        we_nxt = 1'b0;
        if (cnt == LAT) begin
          lo_nxt  = mem_dataout;
          cnt_nxt = '0;
          if (op_byte) state_nxt = DONE;
          else begin
            addr_nxt  = op_addr + 12'd1;
            state_nxt = RD_HI;
          end
        end else cnt_nxt = cnt + 3'd1;
      end
      RD_HI: begin
        we_nxt = 1'b0;
        if (cnt == LAT) begin
          hi_nxt    = mem_dataout;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else cnt_nxt = cnt + 3'd1;
      end
      DONE: begin
        we_nxt   = 1'b0;
        done_nxt = 1'b1;
        if (!op_we) rdata_nxt = op_byte ? {8'h00, lo_q} : {hi_q, lo_q};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      op_we            <= 1'b0;
      op_byte          <= 1'b0;
      op_addr          <= '0;
      op_wdata         <= '0;
      lo_q             <= '0;
      hi_q             <= '0;
      cnt              <= '0;
      cpu_busy         <= 1'b0;
      cpu_done         <= 1'b0;
      cpu_rdata        <= '0;
      mem_address      <= '0;
      mem_datain       <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      state            <= state_nxt;
      op_we            <= op_we_nxt;
      op_byte          <= op_byte_nxt;
      op_addr          <= op_addr_nxt;
      op_wdata         <= op_wdata_nxt;
      lo_q             <= lo_nxt;
      hi_q             <= hi_nxt;
      cnt              <= cnt_nxt;
      cpu_busy         <= busy_nxt;
      cpu_done         <= done_nxt;
      cpu_rdata        <= rdata_nxt;
      mem_address      <= addr_nxt;
      mem_datain       <= din_nxt;
      mem_write_enable <= we_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a LAT=1 and a LAT=3 instance, each on its own memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_clr = 1'b0;
  always #5 clk = ~clk;

  logic        req [2], we [2], byt [2];
  logic [11:0] addr [2];
  logic [15:0] wdata [2];
  logic        busy [2], done [2], mwe [2];
  logic [15:0] rdata [2];
  logic [11:0] maddr [2];
  logic [7:0]  mdin [2], mdout [2];

  mem_access_unit #(.MEM_RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_req(req[0]), .cpu_we(we[0]), .cpu_byte(byt[0]),
    .cpu_addr(addr[0]), .cpu_wdata(wdata[0]), .cpu_busy(busy[0]), .cpu_done(done[0]),
    .cpu_rdata(rdata[0]), .mem_address(maddr[0]), .mem_datain(mdin[0]),
    .mem_write_enable(mwe[0]), .mem_dataout(mdout[0]));

  mem_access_unit #(.MEM_RD_LAT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_req(req[1]), .cpu_we(we[1]), .cpu_byte(byt[1]),
    .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_busy(busy[1]), .cpu_done(done[1]),
    .cpu_rdata(rdata[1]), .mem_address(maddr[1]), .mem_datain(mdin[1]),
    .mem_write_enable(mwe[1]), .mem_dataout(mdout[1]));

  // Synchronous memories: read data appears 1 (mem0) or 3 (mem1) edges after the address.
  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];
  logic [7:0] rd0;
  logic [7:0] p1 [3];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= 8'h00;
        mem1[i] <= 8'h00;
      end
    end else begin
      if (mwe[0]) mem0[maddr[0]] <= mdin[0];
      if (mwe[1]) mem1[maddr[1]] <= mdin[1];
    end
    rd0   <= mem0[maddr[0]];
    p1[0] <= mem1[maddr[1]];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign mdout[0] = rd0;
  assign mdout[1] = p1[2];

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction; lat = edges from acceptance to done, -1 on timeout.
  // Returns one edge after done so the unit is idle and unbusy again.
  task automatic run_op(input int s, input logic w, input logic b, input logic [11:0] a,
                        input logic [15:0] d, output int lat);
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; byt[s] = b; addr[s] = a; wdata[s] = d;
    @(posedge clk); #1;
    req[s] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done[s]) begin
        lat = i;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        w;
    logic        b;
    logic [11:0] a;
    logic [15:0] d;
    int          lat;
    logic [15:0] rdata;
    logic [11:0] ma;
    logic [7:0]  mv;
  } vec_t;

  vec_t vt [10];

  initial begin
    int lat;
    int bad;
    int ndone;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; byt[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
    end

    //           we    byte  addr     wdata     lat rdata     mem addr  mem val
    vt[0] = '{1'b1, 1'b0, 12'h010, 16'hBEEF, 3, 16'h0000, 12'h010, 8'hEF};
    vt[1] = '{1'b1, 1'b1, 12'h021, 16'h0077, 2, 16'h0000, 12'h021, 8'h77};
    vt[2] = '{1'b0, 1'b0, 12'h010, 16'h0000, 5, 16'hBEEF, 12'h011, 8'hBE};
    vt[3] = '{1'b1, 1'b1, 12'h020, 16'h12A5, 2, 16'hBEEF, 12'h020, 8'hA5};
    vt[4] = '{1'b0, 1'b1, 12'h020, 16'h0000, 3, 16'h00A5, 12'h021, 8'h77};
    vt[5] = '{1'b1, 1'b0, 12'hFFF, 16'h3C4D, 3, 16'h00A5, 12'h000, 8'h3C};
    vt[6] = '{1'b0, 1'b0, 12'hFFF, 16'h0000, 5, 16'h3C4D, 12'hFFF, 8'h4D};
    vt[7] = '{1'b1, 1'b0, 12'h100, 16'h1234, 3, 16'h3C4D, 12'h101, 8'h12};
    vt[8] = '{1'b0, 1'b1, 12'h101, 16'h0000, 3, 16'h0012, 12'h100, 8'h34};
    vt[9] = '{1'b0, 1'b0, 12'h020, 16'h0000, 5, 16'h77A5, 12'h020, 8'hA5};

    // reset and idle
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    chk("reset_outputs", {busy[0], done[0], mwe[0], rdata[0], maddr[0], mdin[0]}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mwe[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // directed vectors
    for (int i = 0; i < 10; i++) begin
      run_op(0, vt[i].w, vt[i].b, vt[i].a, vt[i].d, lat);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_rdata", i), rdata[0], vt[i].rdata);
      chk($sformatf("v%0d_mem", i), mem0[vt[i].ma], vt[i].mv);
      chk($sformatf("v%0d_idle_after", i), {busy[0], done[0], mwe[0]}, 3'b000);
    end

    // busy rejection: cpu_req held high while address/data change every cycle
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; byt[0] = 1'b1;
    bad = 0;
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      addr[0] = 12'h300 + 12'(k);
      wdata[0] = 16'(k) + 16'h0040;
      @(posedge clk); #1;
      if (done[0]) ndone++;
      if (busy[0] !== ((k % 4) != 3)) bad++;
      @(negedge clk);
    end
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_window_pattern", bad, 0);
    chk("busy_done_count", ndone, 4);
    for (int k = 0; k < 16; k++)
      chk($sformatf("busy_mem_%0h", 12'h300 + 12'(k)), mem0[12'h300 + 12'(k)],
          ((k % 4) == 0) ? 8'(k + 'h40) : 8'h00);

    // reset during RD_HI of a word load
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; byt[0] = 1'b0; addr[0] = 12'h010;
    @(posedge clk); #1 req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("rst_rdhi_outputs", {busy[0], done[0], mwe[0], maddr[0], rdata[0]}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    chk("rst_rdhi_no_done", bad, 0);

    // reset during the high-byte strobe of a word store
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; byt[0] = 1'b0; addr[0] = 12'h400; wdata[0] = 16'h5566;
    @(posedge clk); #1 req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk("wrhi_strobe_high", mwe[0], 1'b1);
    rst_n = 1'b0;
    #1 chk("rst_wrhi_we_drop", mwe[0], 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("partial_lo_written", mem0[12'h400], 8'h66);
    chk("partial_hi_untouched", mem0[12'h401], 8'h00);
    run_op(0, 1'b0, 1'b1, 12'h400, 16'h0000, lat);
    chk("post_reset_byte_load", rdata[0], 16'h0066);

    // MEM_RD_LAT = 3 instance
    run_op(1, 1'b1, 1'b0, 12'h010, 16'hBEEF, lat);
    chk("lat3_store_latency", lat, 3);
    run_op(1, 1'b0, 1'b0, 12'h010, 16'h0000, lat);
    chk("lat3_load_latency", lat, 9);
    chk("lat3_load_rdata", rdata[1], 16'hBEEF);
    run_op(1, 1'b0, 1'b1, 12'h011, 16'h0000, lat);
    chk("lat3_byte_latency", lat, 5);
    chk("lat3_byte_rdata", rdata[1], 16'h00BE);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
